// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer for the 20x10 playfield store: drops full rows, compacts the rest downward, zero-fills the top.
// Optional LINE_CLEAR_SCORE_EN adds a saturating score accumulator output.
module line_clear_ctrl #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int CELL_W = 3,
    parameter int RW     = $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [RW-1:0]          lines_cleared,
    output logic [RW-1:0]          rd_row,
    input  logic [COLS*CELL_W-1:0] rd_data,
    output logic                   wr_en,
    output logic [RW-1:0]          wr_row,
    output logic [COLS*CELL_W-1:0] wr_data
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [19:0]            score
`endif
);

    typedef enum logic [2:0] {IDLE, RD, EVAL, FILL, DONE} state_t;

    localparam logic [RW-1:0] LAST = RW'(ROWS - 1);

    state_t        state, state_n;
    logic [RW-1:0] src, dst, cnt, cnt_nxt;
    logic          full;

    always_comb begin
        full = 1'b1;
        for (int c = 0; c < COLS; c++)
            if (rd_data[c*CELL_W +: CELL_W] == '0) full = 1'b0;
    end

    assign cnt_nxt = cnt + RW'(full);

    // Write port is a Moore output of EVAL/FILL; rd_data feeds straight through on a move.
    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        wr_row  = '0;
        wr_data = '0;
        case (state)
            IDLE: if (start) state_n = RD;
            RD:   state_n = EVAL;
            EVAL: begin
                if (!full && src != dst) begin
                    wr_en   = 1'b1;
                    wr_row  = dst;
                    wr_data = rd_data;
                end
                if (src == '0) state_n = (cnt_nxt != '0) ? FILL : DONE;
                else           state_n = RD;
            end
            FILL: begin
                wr_en  = 1'b1;
                wr_row = dst;
                if (dst == '0) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [19:0] score_inc;
    logic [20:0] score_sum;

    always_comb begin
        case (cnt)
            RW'(0):  score_inc = 20'd0;
            RW'(1):  score_inc = 20'd40;
            RW'(2):  score_inc = 20'd100;
            RW'(3):  score_inc = 20'd300;
            default: score_inc = 20'd1200;
        endcase
    end

    assign score_sum = {1'b0, score} + {1'b0, score_inc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            score <= '0;
        else if (state == DONE)
            score <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            rd_row        <= '0;
            src           <= LAST;
            dst           <= LAST;
            cnt           <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
            case (state)
                IDLE: if (start) begin
                    src    <= LAST;
                    dst    <= LAST;
                    cnt    <= '0;
                    rd_row <= LAST;
                end
                EVAL: begin
                    cnt <= cnt_nxt;
                    if (!full) dst <= dst - 1'b1;
                    if (src != '0) begin
                        src    <= src - 1'b1;
                        rd_row <= src - 1'b1;
                    end
                end
                FILL:    if (dst != '0) dst <= dst - 1'b1;
                DONE:    lines_cleared <= cnt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: a behavioural row store, a write scoreboard and per-pass timing/result checks.
module tb_line_clear_ctrl;

    localparam int ROWS = 20, COLS = 10, CELL_W = 3, RW = 5, DW = COLS * CELL_W;

    logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic          busy, done, wr_en;
    logic [RW-1:0] lines_cleared, rd_row, wr_row;
    logic [DW-1:0] rd_data, wr_data;
`ifdef LINE_CLEAR_SCORE_EN
    logic [19:0]   score;
`endif

    line_clear_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .rd_row(rd_row), .rd_data(rd_data),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data)
`ifdef LINE_CLEAR_SCORE_EN
        , .score(score)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [ROWS];
    logic [DW-1:0] g [ROWS];
    logic [DW-1:0] exp_g [ROWS];
    logic          load = 1'b0, mon_en = 1'b1;
    logic [RW-1:0] q_row [$];
    logic [DW-1:0] q_data [$];
    int            vectors = 0, errors = 0;
    int            exp_score = 0;

    // Store model: synchronous read, row write strobe, bulk load from g.
    always @(posedge clk) begin
        if (load)       mem <= g;
        else if (wr_en) mem[wr_row] <= wr_data;
        rd_data <= mem[rd_row];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && wr_en) begin
            if (q_row.size() == 0) check("unexpected_wr", {59'd0, wr_row}, 64'hFFFF);
            else begin
                check("wr_row", {59'd0, wr_row}, {59'd0, q_row.pop_front()});
                check("wr_data", {34'd0, wr_data}, {34'd0, q_data.pop_front()});
            end
        end
    end

    function automatic bit is_full(input logic [DW-1:0] r);
        for (int c = 0; c < COLS; c++) if (r[c*CELL_W +: CELL_W] == 3'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [DW-1:0] rnd_row(input bit full_row);
        logic [DW-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*CELL_W +: CELL_W] = 3'($urandom_range(full_row ? 1 : 0, 7));
        if (!full_row) r[$urandom_range(0, COLS-1)*CELL_W +: CELL_W] = 3'd0;
        return r;
    endfunction

    // Reference: surviving rows keep bottom-up order packed at the bottom; top cnt rows zeroed.
    function automatic int model();
        int dst = ROWS - 1, cnt = 0;
        for (int src = ROWS - 1; src >= 0; src--) begin
            if (is_full(g[src])) cnt++;
            else begin
                if (src != dst) begin q_row.push_back(RW'(dst)); q_data.push_back(g[src]); end
                exp_g[dst] = g[src];
                dst--;
            end
        end
        for (int r = cnt - 1; r >= 0; r--) begin
            q_row.push_back(RW'(r)); q_data.push_back('0); exp_g[r] = '0;
        end
        return cnt;
    endfunction

    task automatic load_grid();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_pass(input string tag, input bit repulse);
        int n, cnt, inc;
        load_grid();
        cnt = model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check({tag, "_busy_c1"}, {63'd0, busy}, 64'd1);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            start = (repulse && n == 10);
            check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 64'(n), 64'(2*ROWS + 1 + cnt));
        @(negedge clk);
        check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_lines"}, {59'd0, lines_cleared}, 64'(cnt));
        check({tag, "_wr_left"}, 64'(q_row.size()), 64'd0);
        q_row.delete(); q_data.delete();
        inc = (cnt == 0) ? 0 : (cnt == 1) ? 40 : (cnt == 2) ? 100 : (cnt == 3) ? 300 : 1200;
        exp_score = (exp_score + inc > 1048575) ? 1048575 : exp_score + inc;
`ifdef LINE_CLEAR_SCORE_EN
        check({tag, "_score"}, {44'd0, score}, 64'(exp_score));
`endif
        repeat (4) begin
            @(negedge clk);
            check({tag, "_no_redone"}, {62'd0, done, busy}, 64'd0);
        end
        for (int r = 0; r < ROWS; r++) check({tag, "_grid"}, {34'd0, mem[r]}, {34'd0, exp_g[r]});
    endtask

    task automatic set_grid(input int n_full_rand);
        for (int r = 0; r < ROWS; r++) g[r] = '0;
        for (int k = 0; k < n_full_rand; k++) g[ROWS-1-3*k] = rnd_row(1'b1);
    endtask

    initial begin
        logic [DW-1:0] pat;
        for (int r = 0; r < ROWS; r++) g[r] = '0;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("rst_lines", {59'd0, lines_cleared}, 64'd0);
        check("rst_rd_row", {59'd0, rd_row}, 64'd0);
        check("rst_wr_row", {59'd0, wr_row}, 64'd0);
        check("rst_wr_data", {34'd0, wr_data}, 64'd0);
`ifdef LINE_CLEAR_SCORE_EN
        check("rst_score", {44'd0, score}, 64'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Four full rows with random debris between them.
        for (int r = 0; r < ROWS; r++) g[r] = (r >= 8) ? rnd_row(1'b0) : '0;
        g[19] = rnd_row(1'b1); g[15] = rnd_row(1'b1); g[14] = rnd_row(1'b1); g[9] = rnd_row(1'b1);
        run_pass("four", 1'b0);

        // Rows 19 and 17 full, rows 18 and 16 distinct patterns.
        set_grid(0);
        g[19] = rnd_row(1'b1); g[17] = rnd_row(1'b1);
        g[18] = 30'h0000_0249; g[16] = 30'h2400_0007;
        run_pass("two", 1'b0);

        // Row 19 full, row 18 holds only cell 0.
        set_grid(1);
        pat = '0; pat[2:0] = 3'b001; g[18] = pat;
        run_pass("one", 1'b0);

        set_grid(0);
        run_pass("empty", 1'b0);

        for (int r = 0; r < ROWS; r++) g[r] = rnd_row(1'b1);
        run_pass("allfull", 1'b0);

        for (int r = 0; r < ROWS; r++) g[r] = rnd_row(r % 5 == 0);
        run_pass("repulse", 1'b1);

        // Abort in the middle of FILL, then run a clean pass.
        set_grid(0);
        g[19] = rnd_row(1'b1); g[17] = rnd_row(1'b1); g[18] = rnd_row(1'b0);
        mon_en = 1'b0;
        load_grid();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_in_fill", {63'd0, wr_en}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort_wr_en", {63'd0, wr_en}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_rd_row", {59'd0, rd_row}, 64'd0);
        exp_score = 0;
        @(negedge clk);
        reset_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        run_pass("fresh", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
- Sequencer that performs Tetris line clears on the 20x10 playfield store after a piece locks.
- Scans rows bottom-to-top through the store's read port and drops full rows.
- Compacts the remaining rows downward through the write port, then zero-fills the vacated top rows.
- Reports the count of cleared lines to game logic. The store itself holds no clearing logic; this block owns all row moves.

Parameters:
- ROWS, 20, playfield rows; row 0 = top, ROWS-1 = bottom
- COLS, 10, playfield columns
- CELL_W, 3, bits per cell; 0 = empty, nonzero = colour
- RW, $clog2(ROWS) (5), row index width

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run a clear pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive
- done  out  1  one-cycle pulse when the pass completes
- lines_cleared  out  RW  full rows removed by the last pass; held until the next pass completes
- rd_row  out  RW  store read row address
- rd_data  in  COLS*CELL_W  row contents; valid one cycle after rd_row (synchronous read); cell c at bits [c*CELL_W +: CELL_W]
- wr_en  out  1  store row write strobe
- wr_row  out  RW  store write row address
- wr_data  out  COLS*CELL_W  row contents to write

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, done=0, wr_en=0, lines_cleared=0, rd_row=0, wr_row=0, wr_data=0, src=dst=ROWS-1, cnt=0.
- Full row: every one of the COLS cells is nonzero.
- IDLE: start=1 -> load src=dst=ROWS-1, cnt=0 -> RD.
- RD: drive rd_row=src -> EVAL.
- EVAL: rd_data is valid for row src.
  - Full row: cnt+=1; no write.
  - Not full and src!=dst: wr_en=1, wr_row=dst, wr_data=rd_data; then dst-=1.
  - Not full and src==dst: no write (no move needed); dst-=1.
  - Exit: if src==0, go to FILL when cnt>0, else DONE. Otherwise src-=1 -> RD.
- FILL: wr_en=1, wr_row=dst, wr_data=0.
  - dst==0: -> DONE.
  - Otherwise: dst-=1, stay in FILL.
  - FILL writes exactly cnt rows (cnt-1 down to 0).
- DONE: done=1 for one cycle; lines_cleared<=cnt; -> IDLE.
- Outputs are registered except wr_en/wr_row/wr_data, which are Moore outputs of EVAL/FILL. wr_en is never high outside EVAL/FILL.
- Latency, with start sampled at edge 0: done is high in cycle 2*ROWS+1+cnt (41 with no clears, 45 with 4 clears).
- start while busy: ignored, not queued.
- All ROWS rows full: no compaction writes; FILL zeroes all rows; lines_cleared=20.
- Reset mid-pass: abort immediately. Store contents are left partially compacted; the block does not repair them.
- Counter widths: cnt is RW bits; it cannot exceed ROWS, so no overflow handling is needed.

Optional Feature:
- Macro: LINE_CLEAR_SCORE_EN.
- Defined: adds output score (20 bits, reset 0). In the DONE cycle, score += 0/40/100/300/1200 for cnt = 0/1/2/3/>=4. Score saturates at 1048575 and is cleared only by reset_n.
- Undefined: no score port and no score logic; all other behaviour is identical.

Test Plan:
- Empty grid, start pulse -> no wr_en; done in cycle 41; lines_cleared=0; busy high in cycles 1-41.
- Row 19 full, row 18 = cell0 only (3'b001), rows above empty -> writes: row19<=row18 data, row18..1<=row above, row0<=0. lines_cleared=1; done in cycle 42.
- Rows 19 and 17 full, rows 18 and 16 distinct patterns -> row19<=old18, row18<=old16. FILL zeroes rows 1 and 0; lines_cleared=2; done in cycle 43.
- All 20 rows full -> zero EVAL writes; 20 FILL writes of 0; lines_cleared=20; done in cycle 61.
- start re-pulsed at cycle 10 of a pass -> single done; no restart. Assert reset_n low mid-FILL -> wr_en=0, busy=0 immediately; next start runs a fresh pass.
- LINE_CLEAR_SCORE_EN: passes clearing 4, then 2, then 1 lines -> score 1200, 1300, 1340. Pass clearing 0 lines -> score unchanged.
